// File: rtl/cnn_pkg.sv
// cnn_pkg: shared conv2 geometry constants and pixel/window types
package cnn_pkg;
  localparam int DATA_W = 32;
  localparam int CONV2_IMG_W = 15;
  localparam int CONV2_IMG_H = 15;
  localparam int CONV2_CH_NUM = 32;
  typedef logic [DATA_W-1:0] word_t;
  typedef word_t [0:8] window_t;
endpackage

// File: rtl/conv2_window_gen_if.sv
// conv2_window_gen_if: pixel stream in (valid_in/data_in), 3x3 window stream out (data_out/valid_out/ch_idx/last_win/frame_done)
interface conv2_window_gen_if import cnn_pkg::*; #(parameter int CH_NUM = CONV2_CH_NUM);
  logic valid_in;
  word_t data_in;
  window_t data_out;
  logic valid_out;
  logic [$clog2(CH_NUM)-1:0] ch_idx;
  logic last_win;
  logic frame_done;
  modport master (output valid_in, data_in, input data_out, valid_out, ch_idx, last_win, frame_done);
  modport slave (input valid_in, data_in, output data_out, valid_out, ch_idx, last_win, frame_done);
endinterface

// File: rtl/conv2_line_buffer.sv
// conv2_line_buffer: one-row pixel store, read-old-data and write at the same address each cycle
module conv2_line_buffer import cnn_pkg::*; #(parameter int DEPTH = CONV2_IMG_W) (
  input  logic clk,
  input  logic we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  word_t wr_data,
  output word_t rd_data
);
  word_t mem [DEPTH];
  assign rd_data = mem[addr];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wr_data;
endmodule

// File: rtl/conv2_window_gen.sv
// conv2_window_gen: 3x3 valid-conv window generator over a channel-major raster pixel stream
module conv2_window_gen import cnn_pkg::*; #(
  parameter int IMG_W = CONV2_IMG_W,
  parameter int IMG_H = CONV2_IMG_H,
  parameter int CH_NUM = CONV2_CH_NUM
) (
  input logic clk,
  input logic rst_n,
  input logic clear,
  conv2_window_gen_if.slave s
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int HW = $clog2(CH_NUM);
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [HW-1:0] ch;
  word_t lb0_q, lb1_q;
  logic acc, col_end, row_end, ch_end;
  assign acc = s.valid_in & ~clear;
  assign col_end = col == CW'(IMG_W-1);
  assign row_end = row == RW'(IMG_H-1);
  assign ch_end = ch == HW'(CH_NUM-1);
  conv2_line_buffer #(.DEPTH(IMG_W)) lb0 (.clk(clk), .we(acc), .addr(col), .wr_data(s.data_in), .rd_data(lb0_q));
  conv2_line_buffer #(.DEPTH(IMG_W)) lb1 (.clk(clk), .we(acc), .addr(col), .wr_data(lb0_q), .rd_data(lb1_q));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col <= '0;
      row <= '0;
      ch <= '0;
      s.data_out <= '0;
      s.valid_out <= 1'b0;
      s.ch_idx <= '0;
      s.last_win <= 1'b0;
      s.frame_done <= 1'b0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
      ch <= '0;
      s.data_out <= '0;
      s.valid_out <= 1'b0;
      s.ch_idx <= '0;
      s.last_win <= 1'b0;
      s.frame_done <= 1'b0;
    end else begin
      s.valid_out <= acc && row >= RW'(2) && col >= CW'(2);
      s.last_win <= acc && row_end && col_end;
      s.frame_done <= acc && row_end && col_end && ch_end;
      if (acc) begin
        col <= col_end ? '0 : col + 1'b1;
        row <= col_end ? (row_end ? '0 : row + 1'b1) : row;
        ch <= (col_end && row_end) ? (ch_end ? '0 : ch + 1'b1) : ch;
        s.data_out <= {s.data_out[1], s.data_out[2], lb1_q,
                       s.data_out[4], s.data_out[5], lb0_q,
                       s.data_out[7], s.data_out[8], s.data_in};
        s.ch_idx <= ch;
      end
    end
endmodule

// File: tb/tb_conv2_window_gen.sv
// tb_conv2_window_gen: directed self-checking bench for conv2_window_gen
module tb_conv2_window_gen;
  import cnn_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  int errors = 0, checks = 0, wins = 0, fds = 0;
  int tch = 0, tr = 0, tc = 0;
  window_t first_lit = {32'h00, 32'h01, 32'h02, 32'h10, 32'h11, 32'h12, 32'h20, 32'h21, 32'h22};
  always #5 clk = ~clk;
  conv2_window_gen_if bus ();
  conv2_window_gen dut (.clk(clk), .rst_n(rst_n), .clear(clear), .s(bus));
  function automatic word_t px(int ch, int r, int c);
    return word_t'(ch * 256 + r * 16 + c);
  endfunction
  function automatic window_t exp_win(int ch, int r, int c);
    window_t w;
    for (int k = 0; k < 9; k++) w[k] = px(ch, r - 2 + k / 3, c - 2 + k % 3);
    return w;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_win(input string tag, input window_t obs, input window_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step(input bit v);
    logic ev, lw, fd;
    bus.valid_in = v;
    bus.data_in = v ? px(tch, tr, tc) : 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    ev = v && tr >= 2 && tc >= 2;
    lw = v && tr == CONV2_IMG_H - 1 && tc == CONV2_IMG_W - 1;
    fd = lw && tch == CONV2_CH_NUM - 1;
    chk("valid_out", bus.valid_out, ev);
    chk("last_win", bus.last_win, lw);
    chk("frame_done", bus.frame_done, fd);
    if (ev) begin
      chk_win("window", bus.data_out, exp_win(tch, tr, tc));
      chk("ch_idx", bus.ch_idx, tch);
    end
    if (bus.valid_out) wins++;
    if (bus.frame_done) fds++;
    if (v) begin
      tc++;
      if (tc == CONV2_IMG_W) begin
        tc = 0;
        tr++;
        if (tr == CONV2_IMG_H) begin
          tr = 0;
          tch = (tch + 1) % CONV2_CH_NUM;
        end
      end
    end
  endtask
  task automatic chk_zero(input string tag);
    chk_win({tag, "_data"}, bus.data_out, '0);
    chk({tag, "_valid"}, bus.valid_out, 0);
    chk({tag, "_ch"}, bus.ch_idx, 0);
    chk({tag, "_last"}, bus.last_win, 0);
    chk({tag, "_fd"}, bus.frame_done, 0);
  endtask
  initial begin
    bus.valid_in = 1'b0;
    bus.data_in = '0;
    #12;
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (33) step(1);
    chk_win("t1_first", bus.data_out, first_lit);
    chk("t1_valid", bus.valid_out, 1);
    repeat (192) step(1);
    chk("t2_w0", bus.data_out[0], 32'hCC);
    chk("t2_w8", bus.data_out[8], 32'hEE);
    chk("t2_last", bus.last_win, 1);
    chk("t2_ch", bus.ch_idx, 0);
    chk("t2_wins", wins, 169);
    clear = 1'b1;
    bus.valid_in = 1'b1;
    bus.data_in = px(1, 0, 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk_zero("clr0");
    tch = 0;
    tr = 0;
    tc = 0;
    wins = 0;
    fds = 0;
    repeat (225) begin
      step(1);
      step(0);
    end
    chk("t3_wins", wins, 169);
    repeat (33) step(1);
    chk("t4_w0", bus.data_out[0], 32'h100);
    chk("t4_w8", bus.data_out[8], 32'h122);
    chk("t4_ch", bus.ch_idx, 1);
    chk("t4_wins", wins, 170);
    repeat (6975 - 33) step(1);
    chk("t5_fd", bus.frame_done, 1);
    chk("t5_wins", wins, 5408);
    chk("t5_fd_cnt", fds, 1);
    repeat (33) step(1);
    chk("t5_next_ch", bus.ch_idx, 0);
    chk("t5_next_w0", bus.data_out[0], 0);
    chk("t5_next_w8", bus.data_out[8], 32'h22);
    while (!(tch == 3 && tr == 5 && tc == 7)) step(1);
    chk("t6_pre_ch", bus.ch_idx, 3);
    #1 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tch = 0;
    tr = 0;
    tc = 0;
    repeat (33) step(1);
    chk("t6_rst_valid", bus.valid_out, 1);
    chk("t6_rst_w0", bus.data_out[0], 0);
    chk("t6_rst_w8", bus.data_out[8], 32'h22);
    while (!(tch == 3 && tr == 5 && tc == 7)) step(1);
    chk("t6_pre2_ch", bus.ch_idx, 3);
    clear = 1'b1;
    bus.valid_in = 1'b1;
    bus.data_in = px(tch, tr, tc);
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk_zero("sync_clr");
    tch = 0;
    tr = 0;
    tc = 0;
    repeat (33) step(1);
    chk("t6_clr_valid", bus.valid_out, 1);
    chk("t6_clr_w0", bus.data_out[0], 0);
    chk("t6_clr_w4", bus.data_out[4], 32'h11);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
